// File: rtl/lead_one_normalizer_pkg.sv
// Shared defaults, the zero-operand index and the normalized result record
// for the leading-one normalizer.
package lead_one_normalizer_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_IDXW  = 5;
    localparam int DEF_EXPW  = 4;
    localparam int DEF_CNTW  = 8;

    // Index the detector reports for an all-zero operand.
    localparam logic signed [DEF_IDXW-1:0] ZERO_INDEX = DEF_IDXW'(-1);

    typedef struct packed {
        logic [DEF_WIDTH-2:0] mant;
        logic [DEF_EXPW-1:0]  exp;
        logic                 zero;
    } norm_res_t;

endpackage

// File: rtl/lead_one_normalizer_lo_check.sv
// Reference leading-one position of an operand, used only to cross-check the
// index delivered by the upstream detector.
module lead_one_normalizer_lo_check
    import lead_one_normalizer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDXW  = DEF_IDXW
) (
    input  logic [WIDTH-1:0]       data,
    output logic signed [IDXW-1:0] true_index
);

    // Ascending scan: the last hit is the highest set bit, matching the detector.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
        true_index = IDXW'(ZERO_INDEX);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) true_index = IDXW'(i);
        end
    end

endmodule

// File: rtl/lead_one_normalizer.sv
// Two-stage normalizer: left-aligns an operand below its leading one using the
// detector's index, and counts indices that disagree with the operand.
module lead_one_normalizer
    import lead_one_normalizer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDXW  = DEF_IDXW,
    parameter int EXPW  = DEF_EXPW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic signed [IDXW-1:0] in_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-2:0]       out_mant,
    output logic [EXPW-1:0]        out_exp,
    output logic                   out_zero,
    output logic                   err,
    output logic [CNTW-1:0]        err_cnt,
    input  logic                   err_clr
);

    logic                   s1_valid;
    logic [WIDTH-1:0]       s1_data;
    logic signed [IDXW-1:0] s1_index;
    logic                   s1_bad_pulse;
    logic                   s2_ready;
    logic                   in_fire;
    logic signed [IDXW-1:0] true_index;
    logic                   mismatch;
    int                     in_idx;
    int                     s1_idx;
    norm_res_t              norm;
    norm_res_t              s2_res;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign in_fire  = in_valid && in_ready;

    lead_one_normalizer_lo_check #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_lo_check (
        .data       (in_data),
        .true_index (true_index)
    );

    assign in_idx   = int'(in_index);
    assign mismatch = (in_index != true_index) || (in_idx < -1) || (in_idx > WIDTH - 1);

    // Stage 1: operand, given index, and a one-shot flag for a failed check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            s1_index     <= '0;
            s1_bad_pulse <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            s1_bad_pulse <= in_fire && mismatch;
            if (in_ready) s1_valid <= in_valid;
            if (in_fire) begin
                s1_data  <= in_data;
                s1_index <= in_index;
            end
        end
    end

    assign s1_idx = int'(s1_index);

    // The given index is trusted even when the check failed.
    always_comb begin
        norm      = '0;
        norm.zero = 1'b1;
        if (s1_idx >= 0 && s1_idx <= WIDTH - 1) begin
            norm.mant = (WIDTH-1)'(s1_data << (WIDTH - 1 - s1_idx));
            norm.exp  = EXPW'(s1_idx);
            norm.zero = 1'b0;
        end
    end

    // Stage 2: output registers, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s2_res    <= '0;
        end else begin
            if (s2_ready) out_valid <= s1_valid;
            if (s1_valid && s2_ready) s2_res <= norm;
        end
    end

    assign out_mant = s2_res.mant;
    assign out_exp  = s2_res.exp;
    assign out_zero = s2_res.zero;

    // A new mismatch beats a simultaneous clear and restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (s1_bad_pulse) begin
            err <= 1'b1;
            if (err_clr) err_cnt <= CNTW'(1);
            else if (err_cnt != '1) err_cnt <= err_cnt + CNTW'(1);
        end else if (err_clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_lead_one_normalizer.sv
// Directed bench for lead_one_normalizer: latency, boundary indices, error
// bookkeeping, backpressure, counter saturation and mid-flight reset.
module tb_lead_one_normalizer;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [8:0]        in_data = '0;
    logic signed [4:0] in_index = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_mant;
    logic [3:0]        out_exp;
    logic              out_zero;
    logic              err;
    logic [7:0]        err_cnt;
    logic              err_clr = 1'b0;

    lead_one_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_index  (in_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .err       (err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mant;
        logic [3:0] exp;
        logic       zero;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   accepted = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Output monitor: in-order scoreboard plus stability while stalled.
    logic       prev_stall = 1'b0;
    logic [7:0] h_mant;
    logic [3:0] h_exp;
    logic       h_zero;
    exp_t       e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_mant", out_mant, h_mant);
                check("stall_exp", out_exp, h_exp);
                check("stall_zero", out_zero, h_zero);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("mant", out_mant, e.mant);
                    check("exp", out_exp, e.exp);
                    check("zero", out_zero, e.zero);
                    pop_cyc.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            h_mant = out_mant;
            h_exp  = out_exp;
            h_zero = out_zero;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Must be entered just after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [8:0] d, input logic signed [4:0] idx,
                        input logic [7:0] m, input logic [3:0] x, input logic z,
                        input bit clr_after = 1'b0);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_index = idx;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("send_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{m, x, z});
        accepted++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (clr_after) begin
            err_clr = 1'b1;
            @(posedge clk);
            #1;
            err_clr = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic clear_err();
        sync();
        err_clr = 1'b1;
        sync();
        err_clr = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_mant", out_mant, 0);
        check("rst_exp", out_exp, 0);
        check("rst_zero", out_zero, 0);
        check("rst_err", err, 0);
        check("rst_cnt", err_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready, 1);

        // Basic pair and two-cycle latency
        sync();
        send(9'h02C, 5, 8'h60, 4'd5, 1'b0);
        @(negedge clk);
        check("lat_edge_k", out_valid, 0);
        @(negedge clk);
        check("lat_edge_k1", out_valid, 1);
        check("basic_err", err, 0);
        drain();

        // Boundary indices back-to-back
        sync();
        pop_cyc.delete();
        send(9'h000, -5'sd1, 8'h00, 4'd0, 1'b1);
        send(9'h1FF, 5'sd8, 8'hFF, 4'd8, 1'b0);
        send(9'h001, 5'sd0, 8'h00, 4'd0, 1'b0);
        send(9'h100, 5'sd8, 8'h00, 4'd8, 1'b0);
        drain();
        check("bnd_count", pop_cyc.size(), 4);
        for (int i = 1; i < pop_cyc.size(); i++) check("bnd_gap", pop_cyc[i] - pop_cyc[i-1], 1);
        check("bnd_err", err, 0);

        // Mismatch, clear, and clear colliding with a new mismatch
        sync();
        send(9'h02C, 5'sd4, 8'hC0, 4'd4, 1'b0);
        drain();
        check("mm_err", err, 1);
        check("mm_cnt", err_cnt, 1);
        clear_err();
        check("clr_err", err, 0);
        check("clr_cnt", err_cnt, 0);
        sync();
        send(9'h02C, 5'sd4, 8'hC0, 4'd4, 1'b0);
        send(9'h02C, 5'sd4, 8'hC0, 4'd4, 1'b0);
        drain();
        check("mm2_cnt", err_cnt, 2);
        sync();
        send(9'h02C, 5'sd4, 8'hC0, 4'd4, 1'b0, 1'b1);
        drain();
        check("setwins_err", err, 1);
        check("setwins_cnt", err_cnt, 1);
        sync();
        send(9'h02C, 5'sd12, 8'h00, 4'd0, 1'b1);
        drain();
        check("oor_cnt", err_cnt, 2);

        // Backpressure with six queued pairs
        clear_err();
        pop_cyc.delete();
        accepted = 0;
        out_ready = 1'b0;
        fork
            begin
                send(9'h003, 5'sd1, 8'h80, 4'd1, 1'b0);
                send(9'h0A5, 5'sd7, 8'h4A, 4'd7, 1'b0);
                send(9'h155, 5'sd8, 8'h55, 4'd8, 1'b0);
                send(9'h010, 5'sd4, 8'h00, 4'd4, 1'b0);
                send(9'h06B, 5'sd6, 8'hAC, 4'd6, 1'b0);
                send(9'h00D, 5'sd3, 8'hA0, 4'd3, 1'b0);
            end
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_ready", in_ready, 0);
        check("bp_accepted", accepted, 2);
        check("bp_valid", out_valid, 1);
        sync();
        out_ready = 1'b1;
        wait fork;
        drain();
        check("bp_count", pop_cyc.size(), 6);
        check("bp_err", err, 0);

        // Saturating error counter
        sync();
        for (int i = 0; i < 260; i++) send(9'h02C, 5'sd4, 8'hC0, 4'd4, 1'b0);
        drain();
        check("sat_cnt", err_cnt, 255);
        check("sat_err", err, 1);

        // Reset with both stages full
        sync();
        out_ready = 1'b0;
        send(9'h1FF, 5'sd8, 8'hFF, 4'd8, 1'b0);
        send(9'h02C, 5'sd4, 8'hC0, 4'd4, 1'b0);
        @(posedge clk);
        #2;
        check("prerst_valid", out_valid, 1);
        check("prerst_err", err, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_err", err, 0);
        check("midrst_cnt", err_cnt, 0);
        check("midrst_mant", out_mant, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("postrst_ready", in_ready, 1);
        sync();
        send(9'h0A5, 5'sd7, 8'h4A, 4'd7, 1'b0);
        @(negedge clk);
        check("postrst_lat_k", out_valid, 0);
        @(negedge clk);
        check("postrst_lat_k1", out_valid, 1);
        drain();
        check("postrst_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
